// File: rtl/simd_decode_stage.sv
// rtl/simd_decode_stage.sv - SIMD decode stage with output register, one-entry skid and halt/flush control
module simd_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [1:0]       out_ew,
    output logic [3:0]       out_lane_en,
    output logic [31:0]      out_imm,
    output logic             out_use_imm,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic             out_reg_wr,
    output logic             out_halt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             halted
);

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  ew;
        logic [3:0]  lane_en;
        logic [31:0] imm;
        logic        use_imm;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        halt;
        logic        illegal;
    } bundle_t;

    bundle_t            w_dec;
    bundle_t            w_out_nxt;
    bundle_t            w_skid_nxt;
    bundle_t            r_out;
    bundle_t            r_skid;
    logic               r_out_valid;
    logic               r_skid_valid;
    logic               r_in_ready;
    logic               r_halted;
    logic [CNT_W-1:0]   r_illegal_cnt;
    logic               w_alu;
    logic               w_mem;
    logic               w_legal;
    logic               w_in_fire;
    logic               w_drain;
    logic               w_out_valid_nxt;
    logic               w_skid_valid_nxt;
    logic               w_halted_nxt;

    always_comb begin
        w_dec         = '0;
        w_alu         = 1'b0;
        w_mem         = 1'b0;
        w_legal       = 1'b1;
        w_dec.opcode  = in_instr[31:26];
        w_dec.rd      = in_instr[25:21];
        w_dec.rs1     = in_instr[20:16];
        w_dec.rs2     = in_instr[15:11];
        w_dec.ew      = in_instr[10:9];
        w_dec.imm     = {{16{in_instr[15]}}, in_instr[15:0]};
        case (in_instr[31:26])
            6'b000000: ;
            6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110: begin
                w_alu        = 1'b1;
                w_dec.reg_wr = 1'b1;
            end
            6'b001000: begin
                w_alu         = 1'b1;
                w_dec.reg_wr  = 1'b1;
                w_dec.use_imm = 1'b1;
            end
            6'b010000: begin
                w_mem         = 1'b1;
                w_dec.reg_wr  = 1'b1;
                w_dec.use_imm = 1'b1;
                w_dec.mem_rd  = 1'b1;
            end
            6'b010001: begin
                w_mem         = 1'b1;
                w_dec.use_imm = 1'b1;
                w_dec.mem_wr  = 1'b1;
            end
            6'b111111: w_dec.halt = 1'b1;
            default:   w_legal = 1'b0;
        endcase
        if (w_alu && in_instr[10:9] == 2'b11) begin
            w_legal = 1'b0;
        end
        if (w_alu || w_mem) begin
            case (in_instr[10:9])
                2'b00:   w_dec.lane_en = 4'b1111;
                2'b01:   w_dec.lane_en = 4'b0101;
                2'b10:   w_dec.lane_en = 4'b0001;
                default: w_dec.lane_en = 4'b0000;
            endcase
        end
        // Illegal words keep their register/immediate fields but carry no side effects
        if (!w_legal) begin
            w_dec.lane_en = 4'b0000;
            w_dec.use_imm = 1'b0;
            w_dec.mem_rd  = 1'b0;
            w_dec.mem_wr  = 1'b0;
            w_dec.reg_wr  = 1'b0;
            w_dec.halt    = 1'b0;
            w_dec.illegal = 1'b1;
        end
    end

    always_comb begin
        w_in_fire        = in_valid && r_in_ready && !flush;
        w_drain          = !r_out_valid || out_ready;
        w_out_nxt        = r_out;
        w_out_valid_nxt  = r_out_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                w_out_nxt        = r_skid;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_skid_nxt = w_dec;
                end
            end else begin
                w_out_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_out_nxt = w_dec;
                end
            end
        end else if (w_in_fire) begin
            w_skid_nxt       = w_dec;
            w_skid_valid_nxt = 1'b1;
        end
        w_halted_nxt = r_halted || (w_in_fire && w_dec.halt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out         <= '0;
            r_skid        <= '0;
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_out         <= w_out_nxt;
            r_skid        <= w_skid_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_halted      <= w_halted_nxt;
            r_in_ready    <= !w_skid_valid_nxt && !w_halted_nxt && !flush;
            if (w_in_fire && w_dec.illegal && r_illegal_cnt != '1) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_opcode  = r_out.opcode;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_ew      = r_out.ew;
    assign out_lane_en = r_out.lane_en;
    assign out_imm     = r_out.imm;
    assign out_use_imm = r_out.use_imm;
    assign out_mem_rd  = r_out.mem_rd;
    assign out_mem_wr  = r_out.mem_wr;
    assign out_reg_wr  = r_out.reg_wr;
    assign out_halt    = r_out.halt;
    assign out_illegal = r_out.illegal;
    assign illegal_cnt = r_illegal_cnt;
    assign halted      = r_halted;

endmodule

// File: tb/tb_simd_decode_stage.sv
// tb/tb_simd_decode_stage.sv - randomized scoreboard bench for simd_decode_stage
module tb_simd_decode_stage;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [1:0]       out_ew;
    logic [3:0]       out_lane_en;
    logic [31:0]      out_imm;
    logic             out_use_imm;
    logic             out_mem_rd;
    logic             out_mem_wr;
    logic             out_reg_wr;
    logic             out_halt;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;
    logic             halted;
    logic [64:0]      dut_bundle;

    int               checks;
    int               errors;
    logic [64:0]      q[$];
    bit               halted_m;
    int               cnt_m;
    bit               rdy_block;
    int               exp_seq[5] = '{1, 2, 3, 3, 3};

    simd_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_ew(out_ew), .out_lane_en(out_lane_en), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_reg_wr(out_reg_wr), .out_halt(out_halt), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt), .halted(halted)
    );

    assign dut_bundle = {out_opcode, out_rd, out_rs1, out_rs2, out_ew, out_lane_en, out_imm,
                         out_use_imm, out_mem_rd, out_mem_wr, out_reg_wr, out_halt, out_illegal};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bundle {opcode,rd,rs1,rs2,ew,lanes,imm,use_imm,mem_rd,mem_wr,reg_wr,halt,illegal}
    function automatic logic [64:0] ref_decode(input logic [31:0] i);
        logic [5:0] op;
        logic [1:0] ew;
        bit         alu;
        bit         mem;
        bit         legal;
        logic [3:0] lanes;
        logic [5:0] flags;
        op    = i[31:26];
        ew    = i[10:9];
        alu   = (op >= 6'd1 && op <= 6'd6) || op == 6'd8;
        mem   = op == 6'd16 || op == 6'd17;
        legal = op == 6'd0 || op == 6'd63 || mem || (alu && ew != 2'd3);
        lanes = 4'h0;
        if (legal && (alu || mem)) begin
            lanes = (ew == 2'd0) ? 4'hF : (ew == 2'd1) ? 4'h5 : (ew == 2'd2) ? 4'h1 : 4'h0;
        end
        if (legal) begin
            flags = {op == 6'd8 || mem, op == 6'd16, op == 6'd17, alu || op == 6'd16, op == 6'd63, 1'b0};
        end else begin
            flags = 6'b000001;
        end
        return {op, i[25:21], i[20:16], i[15:11], ew, lanes, {{16{i[15]}}, i[15:0]}, flags};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops[10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd16, 6'd17};
        logic [5:0]  op;
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 4) == 0) op = r[31:26];
        else op = ops[$urandom_range(0, 9)];
        if (op == 6'h3F) op = 6'h3E;
        return {op, r[25:0]};
    endfunction

    function automatic bit exp_rdy();
        return q.size() < 2 && !halted_m && !rdy_block;
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        bit          fire_in;
        logic [64:0] d;
        fire_in = v && exp_rdy() && !fl;
        d = ref_decode(ins);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (fl) q.delete();
        else if (fire_in) q.push_back(d);
        if (fire_in && d[0] && cnt_m < CMAX) cnt_m++;
        if (fire_in && d[1]) halted_m = 1'b1;
        rdy_block = fl;
    endtask

    task automatic check_state();
        check("out_valid", 65'(out_valid), 65'(q.size() > 0));
        check("in_ready", 65'(in_ready), 65'(exp_rdy()));
        check("halted", 65'(halted), 65'(halted_m));
        check("illegal_cnt", 65'(illegal_cnt), 65'(cnt_m));
        if (q.size() > 0) check("bundle", dut_bundle, q[0]);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        check_state();
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge(v, ins, ordy, fl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        #1;
        check("rst_out_valid", 65'(out_valid), 65'(0));
        check("rst_in_ready", 65'(in_ready), 65'(0));
        check("rst_bundle", dut_bundle, 65'(0));
        check("rst_cnt", 65'(illegal_cnt), 65'(0));
        check("rst_halted", 65'(halted), 65'(0));
        q.delete();
        halted_m = 1'b0; cnt_m = 0; rdy_block = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", 65'(in_ready), 65'(0));
        @(posedge clk);
        model_edge(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; checks = 0; errors = 0;
        in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        do_reset();

        step(1'b1, 32'h04611000, 1'b1, 1'b0);
        check("vadd_valid", 65'(out_valid), 65'(1));
        check("vadd_opcode", 65'(out_opcode), 65'(1));
        check("vadd_regs", 65'({out_rd, out_rs1, out_rs2}), 65'({5'd3, 5'd1, 5'd2}));
        check("vadd_lanes", 65'(out_lane_en), 65'(4'hF));
        check("vadd_reg_wr", 65'(out_reg_wr), 65'(1));
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 32'h04221200, 1'b0, 1'b0);
        step(1'b1, 32'h08432400, 1'b0, 1'b0);
        check("stall_in_ready", 65'(in_ready), 65'(0));
        step(1'b1, 32'h0C643000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, {6'b001000, 5'd4, 5'd5, 16'hF9F0}, 1'b1, 1'b0);
        check("vaddi_imm", 65'(out_imm), 65'(32'hFFFFF9F0));
        check("vaddi_use_imm", 65'(out_use_imm), 65'(1));
        step(1'b1, 32'h08000600, 1'b1, 1'b0);
        check("vsub_ew3_illegal", 65'(out_illegal), 65'(1));
        check("vsub_ew3_lanes", 65'(out_lane_en), 65'(0));
        check("vsub_ew3_cnt", 65'(illegal_cnt), 65'(1));

        step(1'b1, 32'h10A53000, 1'b0, 1'b0);
        step(1'b1, 32'h14C63000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("flush_out_valid", 65'(out_valid), 65'(0));
        check("flush_in_ready", 65'(in_ready), 65'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_in_ready", 65'(in_ready), 65'(1));

        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0);
        end

        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h04611000, 1'b0, 1'b0);
        step(1'b1, 32'h08611000, 1'b0, 1'b0);
        check("pre_reset_valid", 65'(out_valid), 65'(1));
        do_reset();

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'hF8000000, 1'b1, 1'b0);
            check("cnt_saturation", 65'(illegal_cnt), 65'(exp_seq[k]));
        end

        step(1'b1, 32'hFC000000, 1'b1, 1'b0);
        check("halt_flag", 65'(out_halt), 65'(1));
        check("halt_halted", 65'(halted), 65'(1));
        for (int k = 0; k < 10; k++) begin
            step(1'b1, rand_instr(), 1'b1, 1'b0);
            check("halt_in_ready", 65'(in_ready), 65'(0));
        end
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
